fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core constants: reset vector, instruction width, NOP encoding and
// the fetch state type, also used by the decoder.
package fetch_unit_pkg;

    localparam int          INST_W           = 32;
    localparam int          XLEN             = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Shift-register fetch queue: entries[0] is always the head, so the head
// outputs come straight from flops. Flush wins over dequeue but not enqueue.
module fetch_queue #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq,
    input  logic [WIDTH-1:0]             enq_data,
    input  logic                         deq,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic             pop;
    logic [CNT_W-1:0] base;

    // base is the slot a new entry lands in after this cycle's pop/flush
    always_comb begin
        pop = deq && (count != '0) && !flush;
        if (flush) begin
            base = '0;
        end else if (pop) begin
            base = count - CNT_W'(1);
        end else begin
            base = count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entries[i] <= entries[i+1];
                end
            end
            if (enq) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (base == CNT_W'(i)) begin
                        entries[i] <= enq_data;
                    end
                end
            end
            count <= base + CNT_W'(enq);
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = entries[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: credit-limited in-order requests, redirect
// flush with stale-response dropping, and a RUN/HALT fault state machine.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  INST_WIDTH = INST_W,
    parameter int                  PC_WIDTH   = XLEN,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC),
    parameter int                  FQ_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [PC_WIDTH-1:0]   imem_req_addr_o,
    input  logic                  imem_resp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_resp_data_i,
    input  logic                  imem_resp_err_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic                  fetch_fault_o
);

    localparam int               CNT_W   = $clog2(FQ_DEPTH + 1);
    localparam int               ENTRY_W = 1 + PC_WIDTH + INST_WIDTH;
    localparam logic [CNT_W:0]   CREDITS = FQ_DEPTH[CNT_W:0];

    fetch_state_e        state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] resp_pc;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    drop_count;
    logic [CNT_W-1:0]    q_count;
    logic [CNT_W-1:0]    out_next;
    logic [CNT_W:0]      in_use;
    logic                fire;
    logic                retire;
    logic                accept;
    logic                misaligned;
    logic                enq;
    logic                deq;
    logic                head_valid;
    logic [ENTRY_W-1:0]  enq_data;
    logic [ENTRY_W-1:0]  head_data;

    // resp_pc tracks the PC of the next surviving response: requests since the
    // last redirect are sequential, and responses come back in order.
    always_comb begin
        in_use           = {1'b0, q_count} + {1'b0, outstanding};
        imem_req_valid_o = !rst_i && (state == RUN) && !redirect_i && (in_use < CREDITS);
        fire             = imem_req_valid_o && imem_req_ready_i;
        retire           = imem_resp_valid_i && (outstanding != '0);
        out_next         = outstanding + CNT_W'(fire) - CNT_W'(retire);
        misaligned       = is_misaligned(redirect_pc_i[1:0]);
        accept           = imem_resp_valid_i && !redirect_i && (drop_count == '0);
        enq              = redirect_i ? misaligned : accept;
        deq              = head_valid && inst_ready_i;
        if (redirect_i) begin
            enq_data = {1'b1, redirect_pc_i, {INST_WIDTH{1'b0}}};
        end else if (imem_resp_err_i) begin
            enq_data = {1'b1, resp_pc, {INST_WIDTH{1'b0}}};
        end else begin
            enq_data = {1'b0, resp_pc, imem_resp_data_i};
        end
    end

    // On redirect every request still in flight becomes stale, including
    // any from earlier redirects, so the drop count is simply out_next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_i) begin
                fetch_pc   <= redirect_pc_i;
                resp_pc    <= redirect_pc_i;
                drop_count <= out_next;
                state      <= misaligned ? HALT : RUN;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + PC_WIDTH'(4);
                end
                if (accept) begin
                    resp_pc <= resp_pc + PC_WIDTH'(4);
                end
                if (imem_resp_valid_i && (drop_count != '0)) begin
                    drop_count <= drop_count - CNT_W'(1);
                end
                if (accept && imem_resp_err_i) begin
                    state <= HALT;
                end
            end
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (redirect_i),
        .enq        (enq),
        .enq_data   (enq_data),
        .deq        (deq),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (q_count)
    );

    assign imem_req_addr_o                  = fetch_pc;
    assign inst_valid_o                     = head_valid;
    assign {fetch_fault_o, pc_o, inst_o}    = head_data;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays instruction memory and
// predicts requests and delivered entries from in-flight and expected queues.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_req_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        imem_resp_err_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        fetch_fault_o;

    fetch_unit #(
        .INST_WIDTH (32),
        .PC_WIDTH   (64),
        .RESET_PC   (RST_PC),
        .FQ_DEPTH   (DEPTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .imem_resp_err_i   (imem_resp_err_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .pc_o              (pc_o),
        .fetch_fault_o     (fetch_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        bit          fault;
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    req_t        pending[$];
    entry_t      expq[$];
    logic [63:0] modelPc;
    bit          halted;
    logic [63:0] errAddr;
    int          latMin;
    int          latMax;
    int          cycle;
    int          checkCount;
    int          errorCount;

    function automatic logic [31:0] memData(input logic [63:0] addr);
        return addr[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // Hold reset for n cycles, checking the reset output values on each one.
    task automatic resetDut(input int n);
        @(negedge clk_i);
        rst_i             = 1'b1;
        redirect_i        = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_req_ready_i  = 1'b0;
        inst_ready_i      = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
            checkOutput("rst_req_valid", imem_req_valid_o, 1'b0);
            checkOutput("rst_req_addr", imem_req_addr_o, RST_PC);
            checkOutput("rst_inst_valid", inst_valid_o, 1'b0);
            checkOutput("rst_inst", inst_o, 32'h0);
            checkOutput("rst_pc", pc_o, 64'h0);
            checkOutput("rst_fault", fetch_fault_o, 1'b0);
        end
        pending.delete();
        expq.delete();
        modelPc = RST_PC;
        halted  = 1'b0;
    endtask

    // One clock cycle: drive inputs, serve memory, check outputs, advance model.
    task automatic applyStimulus(input logic redir, input logic [63:0] rpc,
                                 input logic memReady, input logic decReady);
        req_t   r;
        entry_t e;
        bit     respNow;
        bit     expValid;
        bit     fired;
        bit     deqNow;
        bit     isErr;
        @(negedge clk_i);
        rst_i            = 1'b0;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        imem_req_ready_i = memReady;
        inst_ready_i     = decReady;
        respNow = (pending.size() > 0) && (pending[0].due <= cycle);
        isErr   = respNow && (pending[0].addr == errAddr);
        imem_resp_valid_i = respNow;
        imem_resp_data_i  = respNow ? memData(pending[0].addr) : 32'h0;
        imem_resp_err_i   = isErr;
        #1;
        expValid = !halted && !redir && ((expq.size() + pending.size()) < DEPTH);
        checkOutput("req_valid", imem_req_valid_o, expValid);
        if (expValid) checkOutput("req_addr", imem_req_addr_o, modelPc);
        checkOutput("inst_valid", inst_valid_o, expq.size() != 0);
        if (expq.size() != 0) begin
            checkOutput("head_pc", pc_o, expq[0].pc);
            checkOutput("head_inst", inst_o, expq[0].inst);
            checkOutput("head_fault", fetch_fault_o, expq[0].fault);
        end
        fired  = expValid && memReady;
        deqNow = (expq.size() != 0) && decReady;
        if (respNow) r = pending.pop_front();
        if (redir) begin
            expq.delete();
            for (int i = 0; i < pending.size(); i++) pending[i].stale = 1'b1;
            modelPc = rpc;
            halted  = (rpc[1:0] != 2'b00);
            if (halted) begin
                e.fault = 1'b1; e.pc = rpc; e.inst = 32'h0;
                expq.push_back(e);
            end
        end else begin
            if (deqNow) void'(expq.pop_front());
            if (respNow && !r.stale) begin
                e.fault = isErr;
                e.pc    = r.addr;
                e.inst  = isErr ? 32'h0 : memData(r.addr);
                expq.push_back(e);
                if (isErr) halted = 1'b1;
            end
            if (fired) begin
                r.addr  = modelPc;
                r.due   = cycle + int'($urandom_range(latMax, latMin));
                r.stale = 1'b0;
                pending.push_back(r);
                modelPc = modelPc + 64'd4;
            end
        end
        @(posedge clk_i);
        cycle++;
    endtask

    task automatic idle(input int n, input logic memReady, input logic decReady);
        repeat (n) applyStimulus(1'b0, 64'h0, memReady, decReady);
    endtask

    initial begin
        logic [63:0] tgt;
        checkCount = 0;
        errorCount = 0;
        cycle      = 0;
        errAddr    = '1;
        latMin     = 1;
        latMax     = 1;
        rst_i             = 1'b1;
        redirect_i        = 1'b0;
        redirect_pc_i     = '0;
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = '0;
        imem_resp_err_i   = 1'b0;
        inst_ready_i      = 1'b0;

        $display("[TB] streaming fetch from reset");
        resetDut(2);
        idle(12, 1'b1, 1'b1);

        $display("[TB] decoder stall and credit limit");
        idle(8, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b0);
        idle(6, 1'b1, 1'b1);

        $display("[TB] redirect with requests in flight");
        latMin = 3; latMax = 3;
        idle(4, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h8000_1000, 1'b1, 1'b1);
        idle(10, 1'b1, 1'b1);
        latMin = 1; latMax = 1;
        idle(3, 1'b1, 1'b1);

        $display("[TB] misaligned redirect and restart");
        applyStimulus(1'b1, 64'h8000_0102, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h8000_0200, 1'b1, 1'b1);
        idle(8, 1'b1, 1'b1);

        $display("[TB] access fault response");
        errAddr = 64'h8000_0008;
        resetDut(1);
        idle(4, 1'b1, 1'b0);
        idle(8, 1'b1, 1'b1);
        errAddr = '1;

        $display("[TB] PC wrap around");
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1);
        idle(8, 1'b1, 1'b1);

        $display("[TB] reset with queue and requests busy");
        latMin = 2; latMax = 2;
        applyStimulus(1'b1, 64'h8000_0400, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);
        resetDut(2);
        latMin = 1; latMax = 1;
        idle(8, 1'b1, 1'b1);

        $display("[TB] randomized traffic");
        latMin = 1; latMax = 4;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                tgt = 64'h8000_0000 + (64'($urandom_range(0, 1023)) << 2);
                if ($urandom_range(0, 3) == 0) tgt = tgt + 64'($urandom_range(1, 3));
                if ($urandom_range(0, 2) == 0) errAddr = tgt + (64'($urandom_range(0, 6)) << 2);
                else errAddr = '1;
                applyStimulus(1'b1, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            end else begin
                applyStimulus(1'b0, 64'h0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
